// File: rtl/run_length_encoder.sv
// Turns line-timed 1-bit pixel streams into {Y, XStart, XEnd} run records.
// Records are queued in a first-word-fall-through FIFO with a valid/ready read side.
module run_length_encoder #(
  parameter int unsigned Wb = 11,
  parameter int unsigned Hb = 10,
  parameter int unsigned Fb = 4
) (
  input  logic                 clk,
  input  logic                 SRST,
  input  logic                 FrameStart,
  input  logic                 DataEn,
  input  logic                 PixelData,
  output logic                 RunValid,
  input  logic                 RunReady,
  output logic [Hb+2*Wb-1:0]   RunData,
  output logic                 LineDone,
  output logic                 Overflow
);

  localparam int unsigned RecW  = Hb + 2 * Wb;
  localparam int unsigned Depth = 2 ** Fb;
  localparam logic [0:0]  StIdle = 1'b0;
  localparam logic [0:0]  StOpen = 1'b1;
  localparam logic [Wb-1:0] XMax = '1;
  localparam logic [Wb-1:0] XOne = 1;
  localparam logic [Hb-1:0] YOne = 1;
  localparam logic [Fb-1:0] POne = 1;
  localparam logic [Fb:0]   COne = 1;

  logic [Wb-1:0]   x_q, x_d;
  logic [Hb-1:0]   y_q, y_d;
  logic [Wb-1:0]   xstart_q, xstart_d;
  logic [0:0]      state_q, state_d;
  logic            data_en_q;
  logic            line_done_q;
  logic            overflow_q, overflow_d;
  logic [RecW-1:0] mem_q [Depth];
  logic [Fb-1:0]   wr_ptr_q, rd_ptr_q;
  logic [Fb:0]     count_q, count_d;

  logic            fall;
  logic            push;
  logic            pop;
  logic            full;
  logic            do_write;
  logic            drop;
  logic [Wb-1:0]   xend;

  assign fall = data_en_q & ~DataEn;
  // X already points one past the last foreground pixel when a run closes.
  assign xend = x_q - XOne;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    xstart_d = xstart_q;
    state_d  = state_q;
    push     = 1'b0;
    if (FrameStart) begin
      x_d     = '0;
      y_d     = '0;
      state_d = StIdle;
    end else if (DataEn) begin
      if (x_q != XMax) x_d = x_q + XOne;
      if (state_q == StIdle && PixelData) begin
        state_d  = StOpen;
        xstart_d = x_q;
      end else if (state_q == StOpen && !PixelData) begin
        state_d = StIdle;
        push    = 1'b1;
      end
    end else if (fall) begin
      x_d = '0;
      y_d = y_q + YOne;
      if (state_q == StOpen) begin
        state_d = StIdle;
        push    = 1'b1;
      end
    end
  end

  assign RunValid = (count_q != '0);
  assign RunData  = RunValid ? mem_q[rd_ptr_q] : '0;
  assign pop      = RunValid & RunReady;
  assign full     = (count_q == Depth[Fb:0]);
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (do_write && !pop)      count_d = count_q + COne;
    else if (!do_write && pop) count_d = count_q - COne;
  end

  always_comb begin
    overflow_d = overflow_q;
    if (FrameStart)  overflow_d = 1'b0;
    else if (drop)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge SRST) begin
    if (SRST) begin
      x_q         <= '0;
      y_q         <= '0;
      xstart_q    <= '0;
      state_q     <= StIdle;
      data_en_q   <= 1'b0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      xstart_q    <= xstart_d;
      state_q     <= state_d;
      data_en_q   <= DataEn;
      line_done_q <= fall;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      if (do_write) wr_ptr_q <= wr_ptr_q + POne;
      if (pop)      rd_ptr_q <= rd_ptr_q + POne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= {y_q, xstart_q, xend};
  end

  assign LineDone = line_done_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_run_length_encoder.sv
// Directed bench for run_length_encoder: hand-built lines with expected run records.
module tb_run_length_encoder;

  localparam int Wb = 11;
  localparam int Hb = 10;
  localparam int Fb = 4;
  localparam int RecW = Hb + 2 * Wb;

  logic            clk;
  logic            SRST;
  logic            FrameStart;
  logic            DataEn;
  logic            PixelData;
  logic            RunValid;
  logic            RunReady;
  logic [RecW-1:0] RunData;
  logic            LineDone;
  logic            Overflow;

  int n_checks;
  int n_errors;
  int ld_cnt;
  int got_rd;
  logic [RecW-1:0] got [$];
  logic [RecW-1:0] exp_q [$];
  logic line_buf [0:1023];

  run_length_encoder #(.Wb(Wb), .Hb(Hb), .Fb(Fb)) u_dut (
    .clk        (clk),
    .SRST       (SRST),
    .FrameStart (FrameStart),
    .DataEn     (DataEn),
    .PixelData  (PixelData),
    .RunValid   (RunValid),
    .RunReady   (RunReady),
    .RunData    (RunData),
    .LineDone   (LineDone),
    .Overflow   (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees what the next posedge will act on.
  always @(negedge clk) begin
    if (RunValid && RunReady) got.push_back(RunData);
    if (LineDone) ld_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RecW-1:0] rec(input int y, input int xs, input int xe);
    logic [Hb-1:0] yy;
    logic [Wb-1:0] a;
    logic [Wb-1:0] b;
    yy = y[Hb-1:0];
    a  = xs[Wb-1:0];
    b  = xe[Wb-1:0];
    return {yy, a, b};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int w, input string pat);
    for (int i = 0; i < w; i++) line_buf[i] = (pat.getc(i) == "1");
  endtask

  task automatic run_line(input int w, input bit fs_end);
    for (int i = 0; i < w; i++) begin
      DataEn    = 1'b1;
      PixelData = line_buf[i];
      tick(1);
    end
    DataEn     = 1'b0;
    PixelData  = 1'b0;
    FrameStart = fs_end;
    tick(1);
    FrameStart = 1'b0;
    tick(3);
  endtask

  task automatic check_records(input string tag);
    int n;
    n = got.size() - got_rd;
    check({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_rec%0d", tag, i), 64'(got[got_rd + i]), 64'(exp_q[i]));
    got_rd = got.size();
    exp_q.delete();
  endtask

  task automatic frame_start();
    FrameStart = 1'b1;
    tick(1);
    FrameStart = 1'b0;
  endtask

  initial begin
    int ld0;
    n_checks   = 0;
    n_errors   = 0;
    ld_cnt     = 0;
    got_rd     = 0;
    SRST       = 1'b1;
    FrameStart = 1'b0;
    DataEn     = 1'b0;
    PixelData  = 1'b0;
    RunReady   = 1'b1;
    tick(3);
    check("rst_valid", 64'(RunValid), 64'd0);
    check("rst_data", 64'(RunData), 64'd0);
    check("rst_linedone", 64'(LineDone), 64'd0);
    check("rst_overflow", 64'(Overflow), 64'd0);
    SRST = 1'b0;
    tick(2);
    frame_start();

    // Y=0: single run in the middle of the line
    ld0 = ld_cnt;
    set_line(8, "00111000");
    run_line(8, 1'b0);
    exp_q.push_back(rec(0, 2, 4));
    check_records("t1");
    check("t1_linedone", 64'(ld_cnt - ld0), 64'd1);

    set_line(8, "00000000");
    run_line(8, 1'b0);
    run_line(8, 1'b0);
    // Y=3: second run reaches the last pixel and closes on line end
    set_line(8, "11000011");
    run_line(8, 1'b0);
    exp_q.push_back(rec(3, 0, 1));
    exp_q.push_back(rec(3, 6, 7));
    check_records("t2");

    set_line(4, "0000");
    run_line(4, 1'b0);
    // Y=5: full-width foreground line
    for (int i = 0; i < 640; i++) line_buf[i] = 1'b1;
    run_line(640, 1'b0);
    exp_q.push_back(rec(5, 0, 639));
    check_records("t3");

    // Y=6: 40 single-pixel runs into a 16-deep FIFO with no reader
    RunReady = 1'b0;
    for (int i = 0; i < 80; i++) line_buf[i] = (i % 2 == 0);
    run_line(80, 1'b0);
    check("t4_overflow", 64'(Overflow), 64'd1);
    check("t4_valid", 64'(RunValid), 64'd1);
    check("t4_head", 64'(RunData), 64'(rec(6, 0, 0)));
    tick(3);
    check("t4_head_hold", 64'(RunData), 64'(rec(6, 0, 0)));
    RunReady = 1'b1;
    tick(20);
    for (int k = 0; k < 16; k++) exp_q.push_back(rec(6, 2 * k, 2 * k));
    check_records("t4");
    check("t4_drained", 64'(RunValid), 64'd0);
    check("t4_overflow_sticky", 64'(Overflow), 64'd1);

    // Y=7: FrameStart arrives while a run is still open at line end (X=100)
    for (int i = 0; i < 100; i++) line_buf[i] = (i >= 50);
    run_line(100, 1'b1);
    check_records("t5_none");
    check("t5_overflow_clr", 64'(Overflow), 64'd0);
    set_line(8, "00111000");
    run_line(8, 1'b0);
    exp_q.push_back(rec(0, 2, 4));
    check_records("t5");

    // Y=1: queue three records, then reset mid-line
    RunReady = 1'b0;
    set_line(8, "10101000");
    run_line(8, 1'b0);
    check("t6_pre_valid", 64'(RunValid), 64'd1);
    check("t6_pre_head", 64'(RunData), 64'(rec(1, 0, 0)));
    for (int i = 0; i < 5; i++) begin
      DataEn    = 1'b1;
      PixelData = (i == 2);
      tick(1);
    end
    SRST = 1'b1;
    #1;
    check("t6_async_valid", 64'(RunValid), 64'd0);
    check("t6_async_data", 64'(RunData), 64'd0);
    DataEn    = 1'b0;
    PixelData = 1'b0;
    tick(2);
    SRST = 1'b0;
    got_rd = got.size();
    RunReady = 1'b1;
    tick(2);
    check("t6_post_valid", 64'(RunValid), 64'd0);
    frame_start();
    set_line(8, "00111000");
    run_line(8, 1'b0);
    exp_q.push_back(rec(0, 2, 4));
    check_records("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
